// File: rtl/dma_pkg.sv
// Shared types and AXI encodings for the DMA datapath blocks.
package dma_pkg;

  typedef enum logic [1:0] {IDLE, AW, W, B} state_e;

  localparam logic [2:0]  SIZE_WORD         = 3'b010;
  localparam logic [1:0]  BURST_INCR        = 2'b01;
  localparam logic [1:0]  RESP_OKAY         = 2'b00;
  localparam int unsigned MAX_BURST_DEFAULT = 16;

endpackage

// File: rtl/fifo_axi_wr_drain.sv
// Empties a show-ahead word FIFO onto AXI4 as INCR write bursts, one burst outstanding at a time.
module fifo_axi_wr_drain
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
  parameter logic [3:0]  AXI_ID    = 4'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] dst_addr,
  input  logic [15:0] len_words,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fifo_ren,
  input  logic [31:0] fifo_do,
  input  logic        fifo_empty,
  output logic        fifo_clear,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0]  beats_q, beats_d;
  logic [4:0]  left_q, left_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        clr_q, clr_d;

  logic [4:0]  burst_beats;
  logic [15:0] rem_after;
  logic        w_hs;
  logic        unused_bid;

  // Burst size is derived from the remaining count, so AWLEN stays put while AWVALID waits.
  assign burst_beats = (rem_q >= 16'(MAX_BURST)) ? 5'(MAX_BURST) : rem_q[4:0];
  assign rem_after   = rem_q - {11'd0, beats_q};
  assign w_hs        = WVALID & WREADY;
  assign unused_bid  = ^BID;

  assign AWID     = AXI_ID;
  assign AWADDR   = addr_q;
  assign AWLEN    = 4'(burst_beats - 5'd1);
  assign AWSIZE   = SIZE_WORD;
  assign AWBURST  = BURST_INCR;
  assign AWVALID  = (state_q == AW);
  assign WDATA    = fifo_do;
  assign WSTRB    = 4'hF;
  assign WVALID   = (state_q == W) & ~fifo_empty;
  assign WLAST    = (state_q == W) & (left_q == 5'd1);
  assign fifo_ren = w_hs;
  assign BREADY   = (state_q == B);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign fifo_clear = clr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      left_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      left_q  <= left_d;
      err_q   <= err_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    left_d  = left_q;
    err_d   = err_q;
    done_d  = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (len_words != 16'd0) begin
            state_d = AW;
            addr_d  = dst_addr;
            rem_d   = len_words;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      AW: begin
        if (AWREADY) begin
          state_d = W;
          beats_d = burst_beats;
          left_d  = burst_beats;
        end
      end
      W: begin
        if (w_hs) begin
          left_d = left_q - 5'd1;
          if (left_q == 5'd1) state_d = B;
        end
      end
      B: begin
        if (BVALID) begin
          rem_d  = rem_after;
          addr_d = addr_q + {25'd0, beats_q, 2'b00};
          if (BRESP != RESP_OKAY) begin
            // Abort: drop whatever is left and flush the FIFO so the next job starts clean.
            state_d = IDLE;
            rem_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            clr_d   = 1'b1;
          end else if (rem_after == 16'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = AW;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_axi_wr_drain.sv
// Directed bench: FIFO model plus AXI write slave, scenario tasks with inline checks.
module tb_fifo_axi_wr_drain;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, err, fifo_ren, fifo_empty, fifo_clear;
  logic [31:0] fifo_do;
  logic [3:0]  AWID, AWLEN;
  logic [31:0] AWADDR, WDATA;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, WLAST, WVALID, BREADY;
  logic [3:0]  WSTRB;
  logic        s_awready = 1'b1, s_wready = 1'b1, s_bvalid = 1'b0;
  logic [1:0]  s_bresp = 2'b00;
  logic [3:0]  s_bid = 4'd0;

  fifo_axi_wr_drain #(.MAX_BURST(16), .AXI_ID(4'd0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err), .fifo_ren(fifo_ren), .fifo_do(fifo_do),
    .fifo_empty(fifo_empty), .fifo_clear(fifo_clear),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(s_awready),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(s_wready),
    .BID(s_bid), .BRESP(s_bresp), .BVALID(s_bvalid), .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  // FIFO model: ring of 64 words, free-running pointers.
  logic [31:0] fmem [64];
  int          wr_ptr = 0, rd_ptr = 0;
  logic        force_empty = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr) || force_empty;
  assign fifo_do    = fmem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (!rstn || fifo_clear) rd_ptr <= wr_ptr;
    else if (fifo_ren)       rd_ptr <= rd_ptr + 1;
  end

  // AXI slave and handshake logger; decisions made at negedge apply to the next posedge.
  logic [31:0] aw_addr_log [64];
  logic [3:0]  aw_len_log  [64];
  logic [31:0] w_data_log  [256];
  logic        w_last_log  [256];
  int n_aw = 0, n_w = 0, n_b = 0, n_done = 0, n_clr = 0, n_both = 0, n_unst = 0;
  int cyc = 0, last_b_cyc = 0, last_done_cyc = 0, last_clr_cyc = 0;
  int bad_idx = -1;
  bit stall_mode = 1'b0;
  bit pend_b = 1'b0, b_hs = 1'b0, aw_held = 1'b0, w_held = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic [3:0]  held_len;
  logic        held_wlast;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      s_bvalid = 1'b0; b_hs = 1'b0; pend_b = 1'b0; aw_held = 1'b0; w_held = 1'b0;
      s_awready = 1'b1; s_wready = 1'b1;
    end else begin
      if (b_hs) begin s_bvalid = 1'b0; b_hs = 1'b0; end
      if (pend_b) begin
        s_bvalid = 1'b1;
        s_bresp  = (n_b == bad_idx) ? 2'b10 : 2'b00;
        pend_b   = 1'b0;
      end
      s_awready = stall_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
      s_wready  = stall_mode ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (aw_held && AWVALID && (AWADDR !== held_addr || AWLEN !== held_len)) n_unst++;
      if (w_held && WVALID && (WDATA !== held_wdata || WLAST !== held_wlast)) n_unst++;
      aw_held = AWVALID && !s_awready; held_addr = AWADDR; held_len = AWLEN;
      w_held  = WVALID && !s_wready;   held_wdata = WDATA; held_wlast = WLAST;
      if (AWVALID && s_awready) begin
        if (n_aw < 64) begin aw_addr_log[n_aw] = AWADDR; aw_len_log[n_aw] = AWLEN; end
        n_aw++;
      end
      if (WVALID && s_wready) begin
        if (n_w < 256) begin w_data_log[n_w] = WDATA; w_last_log[n_w] = WLAST; end
        n_w++;
        if (WLAST) pend_b = 1'b1;
      end
      if (s_bvalid && BREADY) begin b_hs = 1'b1; n_b++; last_b_cyc = cyc; end
      if (done) begin n_done++; last_done_cyc = cyc; end
      if (fifo_clear) begin n_clr++; last_clr_cyc = cyc; end
      if (done && busy) n_both++;
    end
  end

  int errors = 0, checks = 0;
  int b_aw, b_w, b_done, b_clr, b_both, b_unst;

  task automatic snap();
    b_aw = n_aw; b_w = n_w; b_done = n_done; b_clr = n_clr; b_both = n_both; b_unst = n_unst;
  endtask

  task automatic push(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr[5:0]] = base + 32'(i);
      wr_ptr++;
    end
  endtask

  task automatic kick(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk); #1;
    dst_addr = a; len_words = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_done > b_done) begin to = 1'b0; break; end
    end
    #1;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, fifo_clear, AWVALID, WVALID, WLAST, BREADY, fifo_ren} !== 9'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {busy, done, err, fifo_clear, AWVALID, WVALID, WLAST, BREADY, fifo_ren});
    end
    checks++;
    if (AWADDR !== 32'h0) begin errors++; $display("FAIL reset_awaddr: got %h expected 0", AWADDR); end
    checks++;
    if ({AWID, AWSIZE, AWBURST, WSTRB} !== {4'd0, 3'b010, 2'b01, 4'hF}) begin
      errors++;
      $display("FAIL constants: got id=%h size=%b burst=%b strb=%h expected 0/010/01/f",
               AWID, AWSIZE, AWBURST, WSTRB);
    end
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_single_burst();
    bit to; int bad = 0;
    snap();
    @(posedge clk); #1 push(5, 32'hA000_0000);
    kick(32'h0000_1000, 16'd5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_done(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: done not seen within 200 cycles"); end
    checks++;
    if (n_aw - b_aw !== 1 || aw_addr_log[b_aw] !== 32'h1000 || aw_len_log[b_aw] !== 4'd4) begin
      errors++;
      $display("FAIL single_aw: count=%0d addr=%h len=%0d expected 1/00001000/4",
               n_aw - b_aw, aw_addr_log[b_aw], aw_len_log[b_aw]);
    end
    for (int i = 0; i < 5; i++)
      if (w_data_log[b_w+i] !== 32'hA000_0000 + 32'(i) || w_last_log[b_w+i] !== (i == 4)) bad++;
    checks++;
    if (n_w - b_w !== 5 || bad !== 0) begin
      errors++; $display("FAIL single_w: beats=%0d bad=%0d expected 5/0", n_w - b_w, bad);
    end
    checks++;
    if (last_done_cyc - last_b_cyc !== 1) begin
      errors++; $display("FAIL single_done_lat: got %0d expected 1", last_done_cyc - last_b_cyc);
    end
    @(posedge clk); #1;
    checks++;
    if (n_done - b_done !== 1 || done !== 1'b0 || busy !== 1'b0 || n_both !== b_both) begin
      errors++;
      $display("FAIL single_done: dones=%0d done=%b busy=%b overlap=%0d expected 1/0/0/0",
               n_done - b_done, done, busy, n_both - b_both);
    end
  endtask

  task automatic test_multi_burst();
    bit to; int bad = 0;
    snap();
    @(posedge clk); #1 push(40, 32'hB000_0000);
    kick(32'h0000_2000, 16'd40);
    repeat (3) @(posedge clk);
    #1 dst_addr = 32'h9000; len_words = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(400, to);
    checks++;
    if (to) begin errors++; $display("FAIL multi_timeout: done not seen within 400 cycles"); end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n_aw - b_aw !== 3 ||
        aw_addr_log[b_aw]   !== 32'h2000 || aw_len_log[b_aw]   !== 4'd15 ||
        aw_addr_log[b_aw+1] !== 32'h2040 || aw_len_log[b_aw+1] !== 4'd15 ||
        aw_addr_log[b_aw+2] !== 32'h2080 || aw_len_log[b_aw+2] !== 4'd7) begin
      errors++;
      $display("FAIL multi_aw: count=%0d a0=%h/%0d a1=%h/%0d a2=%h/%0d expected 3 2000/15 2040/15 2080/7",
               n_aw - b_aw, aw_addr_log[b_aw], aw_len_log[b_aw], aw_addr_log[b_aw+1],
               aw_len_log[b_aw+1], aw_addr_log[b_aw+2], aw_len_log[b_aw+2]);
    end
    for (int i = 0; i < 40; i++)
      if (w_data_log[b_w+i] !== 32'hB000_0000 + 32'(i) ||
          w_last_log[b_w+i] !== (i == 15 || i == 31 || i == 39)) bad++;
    checks++;
    if (n_w - b_w !== 40 || bad !== 0 || rd_ptr !== wr_ptr) begin
      errors++;
      $display("FAIL multi_w: beats=%0d bad=%0d fifo_left=%0d expected 40/0/0",
               n_w - b_w, bad, wr_ptr - rd_ptr);
    end
    checks++;
    if (n_done - b_done !== 1 || n_both !== b_both || busy !== 1'b0) begin
      errors++;
      $display("FAIL multi_done: dones=%0d overlap=%0d busy=%b expected 1/0/0",
               n_done - b_done, n_both - b_both, busy);
    end
  endtask

  task automatic test_underrun();
    bit to; int bad = 0, leak = 0, wmark, rmark;
    snap();
    @(posedge clk); #1 push(8, 32'hC000_0000);
    kick(32'h0000_3000, 16'd8);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_w - b_w >= 3) break;
    end
    #1 force_empty = 1'b1;
    wmark = n_w; rmark = rd_ptr;
    for (int k = 0; k < 3; k++) begin
      #2;
      if (WVALID !== 1'b0 || fifo_ren !== 1'b0) leak++;
      @(posedge clk); #1;
    end
    checks++;
    if (leak !== 0 || n_w !== wmark || rd_ptr !== rmark) begin
      errors++;
      $display("FAIL underrun_stall: leaks=%0d beats=%0d pops=%0d expected 0/0/0",
               leak, n_w - wmark, rd_ptr - rmark);
    end
    force_empty = 1'b0;
    wait_done(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL underrun_timeout: done not seen within 200 cycles"); end
    for (int i = 0; i < 8; i++)
      if (w_data_log[b_w+i] !== 32'hC000_0000 + 32'(i) || w_last_log[b_w+i] !== (i == 7)) bad++;
    checks++;
    if (n_aw - b_aw !== 1 || aw_len_log[b_aw] !== 4'd7 || n_w - b_w !== 8 || bad !== 0) begin
      errors++;
      $display("FAIL underrun_w: aws=%0d len=%0d beats=%0d bad=%0d expected 1/7/8/0",
               n_aw - b_aw, aw_len_log[b_aw], n_w - b_w, bad);
    end
  endtask

  task automatic test_stalls();
    bit to; int bad = 0;
    snap();
    @(posedge clk); #1 push(20, 32'hD000_0000);
    stall_mode = 1'b1;
    kick(32'h0000_4000, 16'd20);
    wait_done(2000, to);
    stall_mode = 1'b0;
    checks++;
    if (to) begin errors++; $display("FAIL stall_timeout: done not seen within 2000 cycles"); end
    checks++;
    if (n_aw - b_aw !== 2 ||
        aw_addr_log[b_aw]   !== 32'h4000 || aw_len_log[b_aw]   !== 4'd15 ||
        aw_addr_log[b_aw+1] !== 32'h4040 || aw_len_log[b_aw+1] !== 4'd3) begin
      errors++;
      $display("FAIL stall_aw: count=%0d a0=%h/%0d a1=%h/%0d expected 2 4000/15 4040/3",
               n_aw - b_aw, aw_addr_log[b_aw], aw_len_log[b_aw], aw_addr_log[b_aw+1], aw_len_log[b_aw+1]);
    end
    for (int i = 0; i < 20; i++)
      if (w_data_log[b_w+i] !== 32'hD000_0000 + 32'(i) ||
          w_last_log[b_w+i] !== (i == 15 || i == 19)) bad++;
    checks++;
    if (n_w - b_w !== 20 || bad !== 0) begin
      errors++; $display("FAIL stall_w: beats=%0d bad=%0d expected 20/0", n_w - b_w, bad);
    end
    checks++;
    if (n_unst - b_unst !== 0) begin
      errors++; $display("FAIL stall_stable: changes while stalled=%0d expected 0", n_unst - b_unst);
    end
  endtask

  task automatic test_error_abort();
    bit to;
    snap();
    bad_idx = n_b + 1;
    @(posedge clk); #1 push(40, 32'hE000_0000);
    kick(32'h0000_5000, 16'd40);
    wait_done(400, to);
    checks++;
    if (to) begin errors++; $display("FAIL err_timeout: done not seen within 400 cycles"); end
    checks++;
    if (err !== 1'b1 || n_clr - b_clr !== 1 || last_clr_cyc !== last_done_cyc) begin
      errors++;
      $display("FAIL err_flags: err=%b clears=%0d clr_cyc=%0d done_cyc=%0d expected 1/1/equal",
               err, n_clr - b_clr, last_clr_cyc, last_done_cyc);
    end
    repeat (10) @(posedge clk);
    #1;
    bad_idx = -1;
    checks++;
    if (n_aw - b_aw !== 2 || aw_addr_log[b_aw+1] !== 32'h5040 || n_w - b_w !== 32) begin
      errors++;
      $display("FAIL err_traffic: aws=%0d a1=%h beats=%0d expected 2/00005040/32",
               n_aw - b_aw, aw_addr_log[b_aw+1], n_w - b_w);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rd_ptr !== wr_ptr || n_done - b_done !== 1) begin
      errors++;
      $display("FAIL err_after: err=%b busy=%b fifo_left=%0d dones=%0d expected 1/0/0/1",
               err, busy, wr_ptr - rd_ptr, n_done - b_done);
    end
  endtask

  task automatic test_len_zero();
    snap();
    kick(32'h0000_7000, 16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL len0_pulse: done=%b busy=%b err=%b awvalid=%b expected 1/0/0/0",
               done, busy, err, AWVALID);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || n_done - b_done !== 1 || n_aw !== b_aw || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_after: done=%b dones=%0d aws=%0d busy=%b expected 0/1/0/0",
               done, n_done - b_done, n_aw - b_aw, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit to; int bad = 0;
    snap();
    @(posedge clk); #1 push(8, 32'hF000_0000);
    kick(32'h0000_6000, 16'd8);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (n_w - b_w >= 2) break;
    end
    #1;
    checks++;
    if (WVALID !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: wvalid=%b busy=%b expected 1/1", WVALID, busy);
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, fifo_clear, AWVALID, WVALID, WLAST, BREADY, fifo_ren} !== 9'h0 ||
        AWADDR !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: outputs=%b awaddr=%h expected 000000000/0",
               {busy, done, err, fifo_clear, AWVALID, WVALID, WLAST, BREADY, fifo_ren}, AWADDR);
    end
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || n_done !== b_done || n_aw - b_aw !== 1 || rd_ptr !== wr_ptr) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b dones=%0d aws=%0d fifo_left=%0d expected 0/0/1/0",
               busy, n_done - b_done, n_aw - b_aw, wr_ptr - rd_ptr);
    end
    snap();
    @(posedge clk); #1 push(3, 32'h1234_0000);
    kick(32'h0000_8000, 16'd3);
    wait_done(200, to);
    for (int i = 0; i < 3; i++)
      if (w_data_log[b_w+i] !== 32'h1234_0000 + 32'(i) || w_last_log[b_w+i] !== (i == 2)) bad++;
    checks++;
    if (to || n_aw - b_aw !== 1 || aw_addr_log[b_aw] !== 32'h8000 || aw_len_log[b_aw] !== 4'd2 ||
        n_w - b_w !== 3 || bad !== 0) begin
      errors++;
      $display("FAIL rstmid_restart: timeout=%0d aws=%0d addr=%h len=%0d beats=%0d bad=%0d expected 0/1/00008000/2/3/0",
               to, n_aw - b_aw, aw_addr_log[b_aw], aw_len_log[b_aw], n_w - b_w, bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_underrun();
    test_stalls();
    test_error_abort();
    test_len_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
